// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the immediate generator pipeline:
//   - fmt_e      : immediate format codes presented on out_fmt
//   - OPC_*      : RV32/RV64 major opcode constants (instr[6:0])
//   - shamt_w()  : width of the OP-IMM shift amount for a given XLEN
// -----------------------------------------------------------------------------
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_Z    = 3'd5,   // CSR zimm (rs1 field)
        FMT_SH   = 3'd6,   // shift amount
        FMT_NONE = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // RV64 shifts reach 63, so the shamt field grows to 6 bits.
    function automatic int unsigned shamt_w(input int unsigned xlen);
        return (xlen == 64) ? 6 : 5;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
// Purely combinational immediate extraction for one 32-bit instruction word.
// Parameters:
//   XLEN      : immediate width, 32 or 64
//   EN_SYSTEM : 1 enables SYSTEM-opcode (CSR) decode, 0 makes it illegal
// Ports:
//   instr   in  32    instruction word
//   imm     out XLEN  extended immediate (0 for NONE / illegal)
//   fmt     out 3     format code (imm_pkg::fmt_e)
//   illegal out 1     opcode not supported in this configuration
// -----------------------------------------------------------------------------
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int EN_SYSTEM = 1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam bit IS64   = (XLEN == 64);
    localparam bit SYS_ON = (EN_SYSTEM != 0);

    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic        sign;
    logic [31:0] shamt_xlen;
    logic [31:0] shamt_5;

    // Immediate is built as a 32-bit value plus a flag saying whether the
    // upper XLEN-32 bits copy bit 31 (sign extension) or stay zero.
    logic [31:0] raw;
    logic        sext;
    fmt_e        fmt_sel;

    assign opc    = instr[6:0];
    assign funct3 = instr[14:12];
    assign sign   = instr[31];

    assign shamt_5    = {27'b0, instr[24:20]};
    assign shamt_xlen = (shamt_w(XLEN) == 6) ? {26'b0, instr[25:20]} : shamt_5;

    always_comb begin
        raw     = '0;
        sext    = 1'b0;
        fmt_sel = FMT_NONE;
        illegal = 1'b0;
        case (opc)
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    fmt_sel = FMT_SH;
                    raw     = shamt_xlen;
                end else begin
                    fmt_sel = FMT_I;
                    raw     = {{20{sign}}, instr[31:20]};
                    sext    = 1'b1;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                fmt_sel = FMT_I;
                raw     = {{20{sign}}, instr[31:20]};
                sext    = 1'b1;
            end
            OPC_STORE: begin
                fmt_sel = FMT_S;
                raw     = {{20{sign}}, instr[31:25], instr[11:7]};
                sext    = 1'b1;
            end
            OPC_BRANCH: begin
                fmt_sel = FMT_B;
                raw     = {{19{sign}}, sign, instr[7], instr[30:25], instr[11:8], 1'b0};
                sext    = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_sel = FMT_U;
                raw     = {instr[31:12], 12'b0};
                sext    = 1'b1;
            end
            OPC_JAL: begin
                fmt_sel = FMT_J;
                raw     = {{11{sign}}, sign, instr[19:12], instr[20], instr[30:21], 1'b0};
                sext    = 1'b1;
            end
            OPC_OP_IMM_32: begin
                if (!IS64) begin
                    illegal = 1'b1;
                end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Word shifts only ever take a 5-bit amount.
                    fmt_sel = FMT_SH;
                    raw     = shamt_5;
                end else begin
                    fmt_sel = FMT_I;
                    raw     = {{20{sign}}, instr[31:20]};
                    sext    = 1'b1;
                end
            end
            OPC_OP_32: begin
                illegal = !IS64;
            end
            OPC_SYSTEM: begin
                if (!SYS_ON) begin
                    illegal = 1'b1;
                end else if (funct3[2]) begin
                    fmt_sel = FMT_Z;
                    raw     = {27'b0, instr[19:15]};
                end else if (funct3 != 3'b000) begin
                    // CSR address is an unsigned index, never sign-extended.
                    fmt_sel = FMT_I;
                    raw     = {20'b0, instr[31:20]};
                end
            end
            OPC_OP, OPC_MISC_MEM: begin
                fmt_sel = FMT_NONE;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign fmt = fmt_sel;

    genvar gi;
    for (gi = 0; gi < XLEN; gi++) begin : g_ext
        if (gi < 32) begin : g_low
            assign imm[gi] = raw[gi];
        end else begin : g_high
            assign imm[gi] = sext & raw[31];
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// One-cycle immediate generator with valid/ready handshake on both sides.
// Decode is combinational (imm_decode); this module holds an output register
// plus a one-entry skid register so in_ready can be a flop.
// Parameters: XLEN (32/64), TAG_W (sideband width), EN_SYSTEM (CSR decode)
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready is registered
//   in_instr, in_tag     instruction word and sideband tag
//   out_valid/out_ready  output handshake
//   out_imm, out_fmt     extended immediate and its format code
//   out_tag, out_illegal tag of this result, unsupported-opcode flag
//   illegal_cnt          saturating count of illegal results delivered
// -----------------------------------------------------------------------------
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 8,
    parameter int EN_SYSTEM = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [15:0]      illegal_cnt
);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;

    imm_decode #(
        .XLEN      (XLEN),
        .EN_SYSTEM (EN_SYSTEM)
    ) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    logic             out_valid_reg, out_valid_next;
    logic [XLEN-1:0]  out_imm_reg,   out_imm_next;
    logic [2:0]       out_fmt_reg,   out_fmt_next;
    logic [TAG_W-1:0] out_tag_reg,   out_tag_next;
    logic             out_ill_reg,   out_ill_next;

    logic             skid_valid_reg, skid_valid_next;
    logic [XLEN-1:0]  skid_imm_reg,   skid_imm_next;
    logic [2:0]       skid_fmt_reg,   skid_fmt_next;
    logic [TAG_W-1:0] skid_tag_reg,   skid_tag_next;
    logic             skid_ill_reg,   skid_ill_next;

    logic             in_ready_reg,   in_ready_next;
    logic [15:0]      cnt_reg,        cnt_next;

    logic push;
    logic pop;

    assign push = in_valid && in_ready_reg;
    assign pop  = out_valid_reg && out_ready;

    always_comb begin
        out_valid_next  = out_valid_reg;
        out_imm_next    = out_imm_reg;
        out_fmt_next    = out_fmt_reg;
        out_tag_next    = out_tag_reg;
        out_ill_next    = out_ill_reg;
        skid_valid_next = skid_valid_reg;
        skid_imm_next   = skid_imm_reg;
        skid_fmt_next   = skid_fmt_reg;
        skid_tag_next   = skid_tag_reg;
        skid_ill_next   = skid_ill_reg;

        if (skid_valid_reg) begin
            // in_ready is low whenever the skid is full, so no push here.
            if (pop) begin
                out_imm_next    = skid_imm_reg;
                out_fmt_next    = skid_fmt_reg;
                out_tag_next    = skid_tag_reg;
                out_ill_next    = skid_ill_reg;
                skid_valid_next = 1'b0;
            end
        end else if (push && (!out_valid_reg || pop)) begin
            out_valid_next = 1'b1;
            out_imm_next   = dec_imm;
            out_fmt_next   = dec_fmt;
            out_tag_next   = in_tag;
            out_ill_next   = dec_ill;
        end else if (push) begin
            // Output stalled: park the new result so nothing is lost.
            skid_valid_next = 1'b1;
            skid_imm_next   = dec_imm;
            skid_fmt_next   = dec_fmt;
            skid_tag_next   = in_tag;
            skid_ill_next   = dec_ill;
        end else if (pop) begin
            out_valid_next = 1'b0;
        end

        in_ready_next = !skid_valid_next;

        cnt_next = cnt_reg;
        if (pop && out_ill_reg && (cnt_reg != 16'hFFFF)) begin
            cnt_next = cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            out_imm_reg    <= '0;
            out_fmt_reg    <= FMT_NONE;
            out_tag_reg    <= '0;
            out_ill_reg    <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_imm_reg   <= '0;
            skid_fmt_reg   <= FMT_NONE;
            skid_tag_reg   <= '0;
            skid_ill_reg   <= 1'b0;
            in_ready_reg   <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_imm_reg    <= out_imm_next;
            out_fmt_reg    <= out_fmt_next;
            out_tag_reg    <= out_tag_next;
            out_ill_reg    <= out_ill_next;
            skid_valid_reg <= skid_valid_next;
            skid_imm_reg   <= skid_imm_next;
            skid_fmt_reg   <= skid_fmt_next;
            skid_tag_reg   <= skid_tag_next;
            skid_ill_reg   <= skid_ill_next;
            in_ready_reg   <= in_ready_next;
            cnt_reg        <= cnt_next;
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign out_imm     = out_imm_reg;
    assign out_fmt     = out_fmt_reg;
    assign out_tag     = out_tag_reg;
    assign out_illegal = out_ill_reg;
    assign illegal_cnt = cnt_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Directed bench for imm_gen_pipe. dut32: XLEN=32, EN_SYSTEM=1.
// dut64: XLEN=64, EN_SYSTEM=0. Shared clock, reset, instr, tag, out_ready.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid32 = 1'b0;
    logic        in_valid64 = 1'b0;
    logic [31:0] in_instr = '0;
    logic [7:0]  in_tag = '0;
    logic        out_ready = 1'b0;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [7:0]  out_tag32;
    logic [15:0] cnt32;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [7:0]  out_tag64;
    logic [15:0] cnt64;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .EN_SYSTEM(1)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_tag(out_tag32),
        .out_illegal(out_illegal32), .illegal_cnt(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .EN_SYSTEM(0)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64),
        .out_illegal(out_illegal64), .illegal_cnt(cnt64)
    );

    typedef struct {
        bit          is64;
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        bit          ill;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [0:NV-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        in_valid32 = 1'b0;
        in_valid64 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one cycle with out_ready=1 and sample the
    // result #1 after the accepting edge.
    task automatic apply(input bit is64, input logic [31:0] instr, input logic [7:0] tag,
                         output logic rdy, output logic ov, output logic [63:0] imm,
                         output logic [2:0] fmt, output logic ill, output logic [7:0] tg);
        @(negedge clk);
        in_instr  = instr;
        in_tag    = tag;
        out_ready = 1'b1;
        if (is64) in_valid64 = 1'b1;
        else      in_valid32 = 1'b1;
        #1;
        rdy = is64 ? in_ready64 : in_ready32;
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        in_valid64 = 1'b0;
        ov  = is64 ? out_valid64 : out_valid32;
        imm = is64 ? out_imm64 : {32'b0, out_imm32};
        fmt = is64 ? out_fmt64 : out_fmt32;
        ill = is64 ? out_illegal64 : out_illegal32;
        tg  = is64 ? out_tag64 : out_tag32;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rdy, ov, ill;
        logic [63:0] imm, exp_imm;
        logic [2:0]  fmt;
        logic [7:0]  tg;
        int          tag_next, hold_acc, model, delivered;
        bit          acc, hit;
        logic [7:0]  rx [$];
        logic [7:0]  got;

        vecs[0]  = '{0, 32'hFFF00093, 64'hFFFFFFFF,         3'd0, 0};
        vecs[1]  = '{0, 32'hFE000EE3, 64'hFFFFFFFC,         3'd2, 0};
        vecs[2]  = '{0, 32'h123450B7, 64'h12345000,         3'd3, 0};
        vecs[3]  = '{0, 32'h4030D093, 64'h3,                3'd6, 0};
        vecs[4]  = '{0, 32'h3002D073, 64'h5,                3'd5, 0};
        vecs[5]  = '{0, 32'hFE112E23, 64'hFFFFFFFC,         3'd1, 0};
        vecs[6]  = '{0, 32'h0080006F, 64'h8,                3'd4, 0};
        vecs[7]  = '{0, 32'h00C08067, 64'hC,                3'd0, 0};
        vecs[8]  = '{0, 32'h002081B3, 64'h0,                3'd7, 0};
        vecs[9]  = '{0, 32'h0FF0000F, 64'h0,                3'd7, 0};
        vecs[10] = '{0, 32'h0020803B, 64'h0,                3'd7, 1};
        vecs[11] = '{0, 32'h0010009B, 64'h0,                3'd7, 1};
        vecs[12] = '{0, 32'hC0002573, 64'hC00,              3'd0, 0};
        vecs[13] = '{0, 32'h00000073, 64'h0,                3'd7, 0};
        vecs[14] = '{0, 32'hFFFFF117, 64'hFFFFF000,         3'd3, 0};
        vecs[15] = '{0, 32'h03F09093, 64'h1F,               3'd6, 0};
        vecs[16] = '{0, 32'hFFF7A003, 64'hFFFFFFFF,         3'd0, 0};
        vecs[17] = '{0, 32'hFFDFF06F, 64'hFFFFFFFC,         3'd4, 0};
        vecs[18] = '{1, 32'h800000B7, 64'hFFFFFFFF80000000, 3'd3, 0};
        vecs[19] = '{1, 32'h0010009B, 64'h1,                3'd0, 0};
        vecs[20] = '{1, 32'h03F09093, 64'h3F,               3'd6, 0};
        vecs[21] = '{1, 32'h03F0D09B, 64'h1F,               3'd6, 0};
        vecs[22] = '{1, 32'h0020803B, 64'h0,                3'd7, 0};
        vecs[23] = '{1, 32'h3002D073, 64'h0,                3'd7, 1};
        vecs[24] = '{1, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd0, 0};
        vecs[25] = '{1, 32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd2, 0};
        vecs[26] = '{1, 32'h0000007F, 64'h0,                3'd7, 1};
        vecs[27] = '{1, 32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'd1, 0};

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid32", 64'(out_valid32), 64'd0);
        check("rst_in_ready32", 64'(in_ready32), 64'd0);
        check("rst_imm32", 64'(out_imm32), 64'd0);
        check("rst_fmt32", 64'(out_fmt32), 64'd7);
        check("rst_tag32", 64'(out_tag32), 64'd0);
        check("rst_ill32", 64'(out_illegal32), 64'd0);
        check("rst_cnt32", 64'(cnt32), 64'd0);
        check("rst_out_valid64", 64'(out_valid64), 64'd0);
        check("rst_fmt64", 64'(out_fmt64), 64'd7);
        check("rst_cnt64", 64'(cnt64), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_in_ready32", 64'(in_ready32), 64'd1);
        check("rst_release_in_ready64", 64'(in_ready64), 64'd1);

        // ---- decode table ----
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].is64, vecs[i].instr, 8'(i), rdy, ov, imm, fmt, ill, tg);
            exp_imm = vecs[i].is64 ? vecs[i].imm : {32'b0, vecs[i].imm[31:0]};
            check($sformatf("v%0d_ready", i), 64'(rdy), 64'd1);
            check($sformatf("v%0d_valid", i), 64'(ov), 64'd1);
            check($sformatf("v%0d_imm", i), imm, exp_imm);
            check($sformatf("v%0d_fmt", i), 64'(fmt), 64'(vecs[i].fmt));
            check($sformatf("v%0d_illegal", i), 64'(ill), 64'(vecs[i].ill));
            check($sformatf("v%0d_tag", i), 64'(tg), 64'(i));
            $display("vec %0d xlen=%0d instr=%08h imm=%0h fmt=%0d ill=%0d",
                     i, vecs[i].is64 ? 64 : 32, vecs[i].instr, imm, fmt, ill);
        end

        // ---- illegal opcode twice, counter ----
        reset_dut();
        for (int k = 0; k < 2; k++) begin
            apply(0, 32'h0000007F, 8'(k), rdy, ov, imm, fmt, ill, tg);
            check("ill_valid", 64'(ov), 64'd1);
            check("ill_flag", 64'(ill), 64'd1);
            check("ill_imm", imm, 64'd0);
            check("ill_fmt", 64'(fmt), 64'd7);
            $display("illegal txn %0d ill=%0d imm=%0h", k, ill, imm);
        end
        @(posedge clk);
        #1;
        check("ill_cnt_2", 64'(cnt32), 64'd2);

        // ---- backpressure: out_ready low for 3 cycles, tags 1..4 ----
        reset_dut();
        tag_next = 1;
        hold_acc = 0;
        for (int cyc = 0; cyc < 20 && rx.size() < 4; cyc++) begin
            @(negedge clk);
            out_ready  = (cyc >= 3);
            in_valid32 = (tag_next <= 4);
            in_tag     = 8'(tag_next);
            in_instr   = 32'h00000013 | (32'(tag_next) << 20);
            #1;
            acc = in_valid32 && in_ready32;
            if (out_valid32 && out_ready) begin
                rx.push_back(out_tag32);
                check("bp_imm", 64'(out_imm32), 64'(out_tag32));
                $display("bp deliver tag=%0d imm=%0h cyc=%0d", out_tag32, out_imm32, cyc);
            end
            if (cyc == 2 || cyc == 3) check("bp_in_ready_low", 64'(in_ready32), 64'd0);
            if (cyc >= 1 && cyc <= 3) begin
                check("bp_hold_valid", 64'(out_valid32), 64'd1);
                check("bp_hold_tag", 64'(out_tag32), 64'd1);
                check("bp_hold_imm", 64'(out_imm32), 64'd1);
            end
            @(posedge clk);
            if (acc) begin
                if (cyc < 3) hold_acc++;
                tag_next++;
            end
        end
        in_valid32 = 1'b0;
        check("bp_accepted_during_hold", 64'(hold_acc), 64'd2);
        check("bp_delivered_count", 64'(rx.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            got = (i < rx.size()) ? rx[i] : 8'hFF;
            check($sformatf("bp_order_%0d", i), 64'(got), 64'(i + 1));
        end

        // ---- reset with both entries full ----
        reset_dut();
        @(negedge clk);
        out_ready  = 1'b0;
        in_valid32 = 1'b1;
        in_tag     = 8'd7;
        in_instr   = 32'h00700013;
        @(negedge clk);
        in_tag     = 8'd8;
        in_instr   = 32'h00800013;
        @(negedge clk);
        in_valid32 = 1'b0;
        check("full_in_ready_low", 64'(in_ready32), 64'd0);
        check("full_out_valid", 64'(out_valid32), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("full_rst_out_valid", 64'(out_valid32), 64'd0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("full_rst_in_ready", 64'(in_ready32), 64'd1);
        delivered = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid32) delivered++;
        end
        check("full_rst_nothing_delivered", 64'(delivered), 64'd0);
        $display("reset-while-full delivered=%0d", delivered);

        // ---- counter saturation ----
        reset_dut();
        @(negedge clk);
        in_instr   = 32'h0000007F;
        in_valid32 = 1'b1;
        out_ready  = 1'b1;
        model = 0;
        hit   = 0;
        for (int cyc = 0; cyc < 70000 && model < 32'h10003; cyc++) begin
            @(negedge clk);
            if (model == 32'hFFFE && !hit) begin
                hit = 1;
                check("sat_cnt_fffe", 64'(cnt32), 64'hFFFE);
            end
            if (out_valid32 && out_ready && out_illegal32) model++;
        end
        in_valid32 = 1'b0;
        @(negedge clk);
        check("sat_budget", 64'(model >= 32'h10003), 64'd1);
        check("sat_cnt_ffff", 64'(cnt32), 64'hFFFF);
        $display("saturation illegal delivered=%0d cnt=%0h", model, cnt32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-002 The block SHALL have parameter XLEN, default 32, giving the immediate width; only 32 and 64 are legal.
REQ-003 The block SHALL have parameter TAG_W, default 8, giving the width of the sideband tag passed through unchanged.
REQ-004 The block SHALL have parameter EN_SYSTEM, default 1; when 1, SYSTEM-opcode decode is enabled.
REQ-005 The block SHALL have these ports, clock and reset first:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  input instruction valid
- in_ready  out  1  block can accept an instruction
- in_instr  in  32  instruction word
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_imm  out  XLEN  extended immediate
- out_fmt  out  3  immediate format code
- out_tag  out  TAG_W  tag of this result
- out_illegal  out  1  opcode not supported
- illegal_cnt  out  16  count of illegal results delivered

Function
REQ-006 Format codes SHALL be: I=0, S=1, B=2, U=3, J=4, Z=5 (CSR zimm), SH=6 (shift amount), NONE=7.
REQ-007 OP-IMM, LOAD and JALR SHALL decode as I, with instr[31:20] sign-extended to XLEN.
- Exception: OP-IMM with funct3 001 or 101 SHALL decode as SH, with zero-extended shamt.
- shamt is instr[24:20] when XLEN=32 and instr[25:20] when XLEN=64.
REQ-008 STORE SHALL decode as S and BRANCH as B, each sign-extended to XLEN; the B format has bit 0 = 0.
REQ-009 LUI and AUIPC SHALL decode as U, giving {instr[31:12], 12'b0} sign-extended to XLEN.
REQ-010 JAL SHALL decode as J, sign-extended to XLEN, with bit 0 = 0.
REQ-011 With XLEN=64, the following SHALL be decoded:
- OP-IMM-32 (0011011) as I; for funct3 001/101 it decodes as SH with 5-bit shamt.
- OP-32 (0111011) as NONE.
With XLEN=32, both opcodes SHALL be illegal.
REQ-012 With EN_SYSTEM=1, SYSTEM (1110011) SHALL decode as follows:
- funct3[2]=1: Z, with instr[19:15] zero-extended.
- funct3 in {001, 010, 011}: I, with instr[31:20] zero-extended.
- funct3=000: NONE.
With EN_SYSTEM=0, SYSTEM SHALL be illegal.
REQ-013 OP (0110011) and MISC-MEM (0001111) SHALL decode as NONE with out_imm=0.
REQ-014 Any other opcode SHALL produce out_illegal=1, out_fmt=NONE and out_imm=0.
REQ-015 A transfer SHALL occur on each side only when valid and ready are both high in the same cycle.
REQ-016 Latency SHALL be 1 cycle: an instruction accepted in cycle N, with the output register empty or popping in N, SHALL present out_valid=1 in N+1.
REQ-017 The block SHALL hold a one-entry skid register. An instruction accepted while out_valid=1 and out_ready=0 SHALL be stored there, and in_ready SHALL be low the next cycle.
REQ-018 in_ready SHALL be registered and equal to NOT skid_valid.
REQ-019 While out_valid=1 and out_ready=0, out_imm, out_fmt, out_tag and out_illegal SHALL be held stable.
REQ-020 On an output pop with the skid register full, the skid entry SHALL move to the output register in the same edge and in_ready SHALL return high.
REQ-021 Push and pop in the same cycle with the skid register empty SHALL load the output register directly and SHALL NOT use the skid register; full throughput is 1 instruction per cycle.
REQ-022 Results SHALL leave in acceptance order; none is dropped or duplicated.
REQ-023 illegal_cnt SHALL increment by 1 on each output transfer with out_illegal=1, and SHALL saturate at 0xFFFF.

Reset
REQ-024 While reset is high, at each edge the block SHALL set:
- out_valid=0, skid_valid=0, in_ready=0
- out_imm=0, out_fmt=NONE, out_tag=0, out_illegal=0
- illegal_cnt=0
REQ-025 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-026 Reset asserted mid-operation SHALL discard both held entries; nothing is delivered afterwards.

Structure
REQ-027 Format codes, opcode constants and the shamt-width function SHALL reside in the shared package imm_pkg.
REQ-028 Decode SHALL be a single combinational sub-module, imm_decode, placed before the output/skid registers; imm_gen_pipe SHALL contain only the registers, handshake and counter.

Verification
REQ-029 The bench SHALL drive this sequence with XLEN=32, out_ready=1 throughout, and check each result one cycle after acceptance:
- 0xFFF00093 -> imm 0xFFFFFFFF, fmt I
- 0xFE000EE3 -> imm 0xFFFFFFFC, fmt B
- 0x123450B7 -> imm 0x12345000, fmt U
REQ-030 With XLEN=32, the bench SHALL check:
- 0x4030D093 (srai) -> fmt SH, imm 3
- 0x3002D073 (csrrwi) -> fmt Z, imm 5
REQ-031 With XLEN=64, 0x800000B7 SHALL give imm 0xFFFFFFFF80000000, and 0x0010009B SHALL give fmt I, imm 1.
REQ-032 The bench SHALL drive 0x0000007F twice and check out_illegal=1, out_imm=0 and illegal_cnt=2; a counter preloaded to 0xFFFF SHALL stay at 0xFFFF.
REQ-033 The bench SHALL hold out_ready=0 for 3 cycles while presenting 4 valid instructions with tags 1-4, then release, and check:
- exactly tags 1 and 2 are accepted
- in_ready stays low until release
- tags 1, 2, 3, 4 are delivered in order
REQ-034 The bench SHALL assert reset while both entries are full and check out_valid=0 the next cycle and in_ready=1 one cycle after reset deasserts.
